// File: rtl/bmc_soft_pipe.sv
// Pipelined soft-decision branch-metric unit for a rate 1/N Viterbi front end.
// Produces metrics for all 2^N codewords and a lowest-metric hint, with valid/ready flow control.
// Optional feature: define BMC_SOFT_PIPE_ERASE_EN to add per-symbol erasure (puncturing) input.
module bmc_soft_pipe #(
  parameter int unsigned N      = 2,
  parameter int unsigned SOFT_W = 3,
  parameter int unsigned IDX_W  = 8
) (
  input  logic                                                    clk,
  input  logic                                                    rst,
  input  logic                                                    in_valid,
  output logic                                                    in_ready,
  input  logic [N*SOFT_W-1:0]                                     in_sym,
  input  logic                                                    in_sof,
`ifdef BMC_SOFT_PIPE_ERASE_EN
  input  logic [N-1:0]                                            in_erase,
`endif
  output logic                                                    out_valid,
  input  logic                                                    out_ready,
  output logic [(2**N)*(SOFT_W+((N == 1) ? 1 : $clog2(N)))-1:0]   out_bm,
  output logic [N-1:0]                                            out_min_idx,
  output logic                                                    out_sof,
  output logic [IDX_W-1:0]                                        out_step
);

  localparam int unsigned NCW  = 2**N;
  localparam int unsigned BM_W = SOFT_W + ((N == 1) ? 1 : $clog2(N));
  localparam logic [SOFT_W-1:0] MAX = {SOFT_W{1'b1}};

  logic                  s1_valid_q, s2_valid_q;
  logic [N*SOFT_W-1:0]   s1_d0_q, s1_d1_q;  // distance to expected bit 0 / bit 1
  logic [N*SOFT_W-1:0]   d1_c;
  logic                  s1_sof_q;
  logic [IDX_W-1:0]      s1_step_q, step_q;
  logic [N-1:0]          s1_erase;
  logic [NCW*BM_W-1:0]   bm_c;
  logic [N-1:0]          min_c;
  logic [BM_W-1:0]       acc, best;
  logic                  in_accept, s2_load;

  // S1 empties into S2 whenever S2 is empty or being consumed this cycle.
  assign s2_load   = s1_valid_q & (!s2_valid_q | out_ready);
  assign in_ready  = !s1_valid_q | !s2_valid_q | out_ready;
  assign in_accept = in_valid & in_ready;
  assign out_valid = s2_valid_q;

  // Distance to an expected '1' is the complement of the soft value.
  always_comb begin
    d1_c = '0;
    for (int i = 0; i < N; i++) begin
      d1_c[i*SOFT_W +: SOFT_W] = MAX - in_sym[i*SOFT_W +: SOFT_W];
    end
  end

  // S1 register: distances, frame flag and step tag; step counter advances per accepted group.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_d0_q    <= '0;
      s1_d1_q    <= '0;
      s1_sof_q   <= 1'b0;
      s1_step_q  <= '0;
      step_q     <= '0;
    end else if (in_accept) begin
      s1_valid_q <= 1'b1;
      s1_d0_q    <= in_sym;
      s1_d1_q    <= d1_c;
      s1_sof_q   <= in_sof;
      s1_step_q  <= in_sof ? '0 : step_q;
      step_q     <= in_sof ? IDX_W'(1) : step_q + IDX_W'(1);
    end else if (s2_load) begin
      s1_valid_q <= 1'b0;
    end
  end

`ifdef BMC_SOFT_PIPE_ERASE_EN
  // Erase mask travels alongside the S1 distances.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_erase <= '0;
    end else if (in_accept) begin
      s1_erase <= in_erase;
    end
  end
`else
  assign s1_erase = '0;
`endif

  // Sum the per-symbol distances for each codeword; strict compare keeps the lowest tied index.
  always_comb begin
    bm_c  = '0;
    min_c = '0;
    acc   = '0;
    best  = '0;
    for (int k = 0; k < NCW; k++) begin
      acc = '0;
      for (int i = 0; i < N; i++) begin
        if (!s1_erase[i]) begin
          if (((k >> i) & 1) == 1) acc = acc + BM_W'(s1_d1_q[i*SOFT_W +: SOFT_W]);
          else                     acc = acc + BM_W'(s1_d0_q[i*SOFT_W +: SOFT_W]);
        end
      end
      bm_c[k*BM_W +: BM_W] = acc;
      if (k == 0 || acc < best) begin
        best  = acc;
        min_c = N'(k);
      end
    end
  end

  // S2 register: metrics and hint, held while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q  <= 1'b0;
      out_bm      <= '0;
      out_min_idx <= '0;
      out_sof     <= 1'b0;
      out_step    <= '0;
    end else if (s2_load) begin
      s2_valid_q  <= 1'b1;
      out_bm      <= bm_c;
      out_min_idx <= min_c;
      out_sof     <= s1_sof_q;
      out_step    <= s1_step_q;
    end else if (out_ready) begin
      s2_valid_q  <= 1'b0;
    end
  end

endmodule
